// File: rtl/microwave_pkg.sv
// Shared definitions for the multi-stage cook controller: FSM state encoding,
// default step/duty constants and a width helper.
package microwave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTING  = 3'd1,
    ST_RUNNING  = 3'd2,
    ST_PAUSED   = 3'd3,
    ST_COMPLETE = 3'd4
  } state_t;

  localparam int unsigned DEF_NUM_STAGES    = 3;
  localparam int unsigned DEF_TIME_W        = 12;
  localparam int unsigned DEF_MAX_TIME      = 3599;
  localparam int unsigned DEF_SMALL_STEP    = 10;
  localparam int unsigned DEF_LARGE_STEP    = 60;
  localparam int unsigned DEF_QUICK_TIME    = 30;
  localparam int unsigned DEF_POWER_LEVELS  = 5;
  localparam int unsigned DEF_BLINK_CYCLES  = 50_000_000;
  localparam int unsigned DEF_BLINK_TOGGLES = 10;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cook_stage_bank.sv
// Stage bank: per-stage time/power registers with saturating add, decrement,
// power cycling, clear and express-load, plus nonzero-stage search.
// Ports: clk/reset; command inputs (clear_all, clear_times, load_quick,
// add_*, dec_*, pwr_*); search_from = stage currently executing;
// outputs current/next times, next powers, nonzero flags and search results.
module cook_stage_bank
  import microwave_pkg::*;
#(
  parameter int unsigned NUM_STAGES   = DEF_NUM_STAGES,
  parameter int unsigned TIME_W       = DEF_TIME_W,
  parameter int unsigned MAX_TIME     = DEF_MAX_TIME,
  parameter int unsigned POWER_LEVELS = DEF_POWER_LEVELS,
  parameter int unsigned QUICK_TIME   = DEF_QUICK_TIME,
  localparam int unsigned SW = clog2_min1(NUM_STAGES),
  localparam int unsigned PW = clog2_min1(POWER_LEVELS + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               clear_all,
  input  logic                               clear_times,
  input  logic                               load_quick,
  input  logic                               add_en,
  input  logic [SW-1:0]                      add_idx,
  input  logic [TIME_W-1:0]                  add_amt,
  input  logic                               dec_en,
  input  logic [SW-1:0]                      dec_idx,
  input  logic                               pwr_en,
  input  logic [SW-1:0]                      pwr_idx,
  input  logic [SW-1:0]                      search_from,
  output logic [NUM_STAGES-1:0][TIME_W-1:0]  time_q,
  output logic [NUM_STAGES-1:0][TIME_W-1:0]  time_d,
  output logic [NUM_STAGES-1:0][PW-1:0]      power_d,
  output logic                               any_q,
  output logic                               any_d,
  output logic [SW-1:0]                      first_idx,
  output logic                               next_valid,
  output logic [SW-1:0]                      next_idx
);

  logic [NUM_STAGES-1:0][PW-1:0] power_q;

  function automatic logic [TIME_W-1:0] sat_add(input logic [TIME_W-1:0] a,
                                                input logic [TIME_W-1:0] b);
    logic [TIME_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > (TIME_W+1)'(MAX_TIME)) ? TIME_W'(MAX_TIME) : s[TIME_W-1:0];
  endfunction

  // Next-value computation; add is saturated before the decrement.
  always_comb begin
    time_d  = time_q;
    power_d = power_q;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (clear_all || clear_times) begin
        time_d[i] = '0;
      end else if (load_quick && i == 0) begin
        time_d[i] = TIME_W'(QUICK_TIME);
      end else begin
        if (add_en && add_idx == SW'(i))
          time_d[i] = sat_add(time_d[i], add_amt);
        if (dec_en && dec_idx == SW'(i) && time_d[i] != '0)
          time_d[i] = time_d[i] - TIME_W'(1);
      end
      if (clear_all || (load_quick && i == 0))
        power_d[i] = PW'(POWER_LEVELS);
      else if (pwr_en && pwr_idx == SW'(i))
        power_d[i] = (power_q[i] >= PW'(POWER_LEVELS)) ? PW'(1) : power_q[i] + PW'(1);
    end
  end

  // Descending scan so the lowest qualifying stage wins.
  always_comb begin
    any_q      = 1'b0;
    any_d      = 1'b0;
    first_idx  = '0;
    next_valid = 1'b0;
    next_idx   = '0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if (time_q[i] != '0) begin
        any_q     = 1'b1;
        first_idx = SW'(i);
      end
      if (time_d[i] != '0)
        any_d = 1'b1;
      if (time_q[i] != '0 && SW'(i) > search_from) begin
        next_valid = 1'b1;
        next_idx   = SW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_q <= '0;
      for (int i = 0; i < int'(NUM_STAGES); i++)
        power_q[i] <= PW'(POWER_LEVELS);
    end else begin
      time_q  <= time_d;
      power_q <= power_d;
    end
  end

endmodule

// File: rtl/multistage_cook_controller.sv
// Multi-stage microwave cook controller: programs NUM_STAGES (time, power)
// stages, executes them in order with power duty cycling, door interlock,
// turntable control and completion blink/alarm.
// Ports: clk, reset (sync, active-high), tick_1hz, btn_* pulses, door_open;
// outputs state, edit_stage, run_stage, display_time, display_power,
// heat_on, motor_enable, button_beep, completion_alarm, display_blink,
// idle_animation (all registered; heat_on additionally gated by door_open).
module multistage_cook_controller
  import microwave_pkg::*;
#(
  parameter int unsigned NUM_STAGES    = DEF_NUM_STAGES,
  parameter int unsigned TIME_W        = DEF_TIME_W,
  parameter int unsigned MAX_TIME      = DEF_MAX_TIME,
  parameter int unsigned SMALL_STEP    = DEF_SMALL_STEP,
  parameter int unsigned LARGE_STEP    = DEF_LARGE_STEP,
  parameter int unsigned QUICK_TIME    = DEF_QUICK_TIME,
  parameter int unsigned POWER_LEVELS  = DEF_POWER_LEVELS,
  parameter int unsigned BLINK_CYCLES  = DEF_BLINK_CYCLES,
  parameter int unsigned BLINK_TOGGLES = DEF_BLINK_TOGGLES,
  localparam int unsigned SW = clog2_min1(NUM_STAGES),
  localparam int unsigned PW = clog2_min1(POWER_LEVELS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              btn_start,
  input  logic              btn_small,
  input  logic              btn_large,
  input  logic              btn_power,
  input  logic              btn_stage,
  input  logic              btn_cancel,
  input  logic              door_open,
  output logic [2:0]        state,
  output logic [SW-1:0]     edit_stage,
  output logic [SW-1:0]     run_stage,
  output logic [TIME_W-1:0] display_time,
  output logic [PW-1:0]     display_power,
  output logic              heat_on,
  output logic              motor_enable,
  output logic              button_beep,
  output logic              completion_alarm,
  output logic              display_blink,
  output logic              idle_animation
);

  localparam int unsigned BW = clog2_min1(BLINK_CYCLES);
  localparam int unsigned TW = clog2_min1(BLINK_TOGGLES + 1);

  state_t                            st, st_d;
  logic [SW-1:0]                     edit_d, run_d, add_idx, sel;
  logic [TIME_W-1:0]                 add_amt;
  logic                              add_req, any_btn, add_en, dec_en, pwr_en;
  logic                              clear_all, clear_times, load_quick, beep_d, expire;
  logic [PW-1:0]                     sec_q, sec_d;
  logic [BW-1:0]                     cnt_q, cnt_d;
  logic [TW-1:0]                     tog_q, tog_d;
  logic                              blink_d, heat_q;
  logic [NUM_STAGES-1:0][TIME_W-1:0] time_q, time_d;
  logic [NUM_STAGES-1:0][PW-1:0]     power_d;
  logic                              any_q, any_d, next_valid;
  logic [SW-1:0]                     first_idx, next_idx;

  cook_stage_bank #(
    .NUM_STAGES   (NUM_STAGES),
    .TIME_W       (TIME_W),
    .MAX_TIME     (MAX_TIME),
    .POWER_LEVELS (POWER_LEVELS),
    .QUICK_TIME   (QUICK_TIME)
  ) u_bank (
    .clk         (clk),
    .reset       (reset),
    .clear_all   (clear_all),
    .clear_times (clear_times),
    .load_quick  (load_quick),
    .add_en      (add_en),
    .add_idx     (add_idx),
    .add_amt     (add_amt),
    .dec_en      (dec_en),
    .dec_idx     (run_stage),
    .pwr_en      (pwr_en),
    .pwr_idx     (edit_stage),
    .search_from (run_stage),
    .time_q      (time_q),
    .time_d      (time_d),
    .power_d     (power_d),
    .any_q       (any_q),
    .any_d       (any_d),
    .first_idx   (first_idx),
    .next_valid  (next_valid),
    .next_idx    (next_idx)
  );

  assign add_req = btn_small | btn_large;
  assign any_btn = btn_start | btn_small | btn_large | btn_power | btn_stage | btn_cancel;
  assign add_amt = (btn_small ? TIME_W'(SMALL_STEP) : '0) + (btn_large ? TIME_W'(LARGE_STEP) : '0);
  // Running stage empties on this tick when (t + add) <= 1; taken from time_q to avoid a loop.
  assign expire  = ({1'b0, time_q[run_stage]} + {1'b0, add_amt}) <= (TIME_W+1)'(1);

  // Event decode: next state, bank commands, duty window and blink sequencing.
  always_comb begin
    st_d        = st;
    edit_d      = edit_stage;
    run_d       = run_stage;
    beep_d      = 1'b0;
    clear_all   = 1'b0;
    clear_times = 1'b0;
    load_quick  = 1'b0;
    add_en      = 1'b0;
    add_idx     = edit_stage;
    dec_en      = 1'b0;
    pwr_en      = 1'b0;
    sec_d       = sec_q;
    cnt_d       = cnt_q;
    blink_d     = display_blink;
    tog_d       = tog_q;

    case (st)
      ST_IDLE: begin
        if (btn_start) begin
          if (!any_q) begin
            load_quick = 1'b1;
            beep_d     = 1'b1;
            run_d      = '0;
            st_d       = door_open ? ST_SETTING : ST_RUNNING;
          end
        end else if (add_req) begin
          add_en = 1'b1;
          beep_d = 1'b1;
          st_d   = ST_SETTING;
        end
      end
      ST_SETTING: begin
        if (btn_start && any_q && !door_open) begin
          st_d   = ST_RUNNING;
          run_d  = first_idx;
          beep_d = 1'b1;
        end else begin
          add_en = add_req;
          pwr_en = btn_power;
          if (btn_stage)
            edit_d = (edit_stage == SW'(NUM_STAGES - 1)) ? '0 : edit_stage + SW'(1);
          beep_d = add_req | btn_power | btn_stage;
        end
      end
      ST_RUNNING: begin
        add_en  = add_req;
        add_idx = run_stage;
        beep_d  = add_req | btn_start;
        if (door_open || btn_start) begin
          st_d = ST_PAUSED;
        end else if (tick_1hz) begin
          dec_en = 1'b1;
          sec_d  = (sec_q == PW'(POWER_LEVELS - 1)) ? '0 : sec_q + PW'(1);
          if (expire) begin
            if (next_valid) run_d = next_idx;
            else            st_d  = ST_COMPLETE;
          end
        end
      end
      ST_PAUSED: begin
        add_en  = add_req;
        add_idx = run_stage;
        beep_d  = add_req;
        if (btn_start && !door_open) begin
          st_d   = ST_RUNNING;
          beep_d = 1'b1;
        end
      end
      ST_COMPLETE: begin
        if (any_btn || door_open) begin
          st_d   = ST_IDLE;
          beep_d = any_btn;
        end else if (cnt_q == BW'(BLINK_CYCLES - 1)) begin
          cnt_d   = '0;
          blink_d = ~display_blink;
          tog_d   = tog_q + TW'(1);
          if (tog_q == TW'(BLINK_TOGGLES - 1)) st_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + BW'(1);
        end
      end
      default: st_d = ST_IDLE;
    endcase

    if (btn_cancel) begin
      st_d       = ST_IDLE;
      edit_d     = '0;
      beep_d     = 1'b1;
      clear_all  = 1'b1;
      add_en     = 1'b0;
      dec_en     = 1'b0;
      pwr_en     = 1'b0;
      load_quick = 1'b0;
    end
    if (st == ST_COMPLETE && st_d == ST_IDLE)
      clear_times = 1'b1;
    if (st_d == ST_RUNNING && st != ST_RUNNING)
      sec_d = '0;
    // Blink sequencer idles armed so COMPLETE always starts at blink=1.
    if (st_d != ST_COMPLETE) begin
      cnt_d   = '0;
      tog_d   = '0;
      blink_d = 1'b1;
    end
  end

  assign sel = (st_d == ST_SETTING) ? edit_d : run_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      st               <= ST_IDLE;
      edit_stage       <= '0;
      run_stage        <= '0;
      sec_q            <= '0;
      cnt_q            <= '0;
      tog_q            <= '0;
      display_blink    <= 1'b1;
      display_time     <= '0;
      display_power    <= '0;
      heat_q           <= 1'b0;
      motor_enable     <= 1'b0;
      button_beep      <= 1'b0;
      completion_alarm <= 1'b0;
      idle_animation   <= 1'b1;
    end else begin
      st               <= st_d;
      edit_stage       <= edit_d;
      run_stage        <= run_d;
      sec_q            <= sec_d;
      cnt_q            <= cnt_d;
      tog_q            <= tog_d;
      display_blink    <= blink_d;
      if (st_d == ST_SETTING || st_d == ST_RUNNING || st_d == ST_PAUSED) begin
        display_time  <= time_d[sel];
        display_power <= power_d[sel];
      end else begin
        display_time  <= '0;
        display_power <= '0;
      end
      heat_q           <= (st_d == ST_RUNNING) && !door_open && (sec_d < power_d[run_d]);
      motor_enable     <= (st_d == ST_RUNNING);
      button_beep      <= beep_d;
      completion_alarm <= (st_d == ST_COMPLETE);
      idle_animation   <= (st_d == ST_IDLE) && !any_d;
    end
  end

  assign state   = st;
  // Door opening kills the magnetron immediately, ahead of the registered path.
  assign heat_on = heat_q & ~door_open;

endmodule

// File: tb/tb_multistage_cook_controller.sv
// Scoreboard bench for multistage_cook_controller: directed stimulus pushes
// expected (cycle, field, value) entries; a negedge monitor pops and compares.
module tb_multistage_cook_controller;

  localparam int unsigned TIME_W = 12;
  localparam int unsigned PW     = 3;
  localparam int unsigned SW     = 2;

  localparam int F_STATE = 0, F_TIME = 1, F_POWER = 2, F_HEAT = 3, F_MOTOR = 4,
                 F_BEEP = 5, F_RUN = 6, F_EDIT = 7, F_ALARM = 8, F_BLINK = 9, F_IDLE = 10;

  localparam logic [6:0] B_TICK   = 7'b1000000;
  localparam logic [6:0] B_START  = 7'b0100000;
  localparam logic [6:0] B_SMALL  = 7'b0010000;
  localparam logic [6:0] B_LARGE  = 7'b0001000;
  localparam logic [6:0] B_POWER  = 7'b0000100;
  localparam logic [6:0] B_STAGE  = 7'b0000010;
  localparam logic [6:0] B_CANCEL = 7'b0000001;

  logic clk = 1'b0;
  logic reset, tick_1hz, btn_start, btn_small, btn_large, btn_power, btn_stage, btn_cancel;
  logic door_open;
  logic [2:0]        state;
  logic [SW-1:0]     edit_stage, run_stage;
  logic [TIME_W-1:0] display_time;
  logic [PW-1:0]     display_power;
  logic heat_on, motor_enable, button_beep, completion_alarm, display_blink, idle_animation;

  always #5 clk = ~clk;

  multistage_cook_controller #(
    .NUM_STAGES(3), .TIME_W(TIME_W), .MAX_TIME(3599), .SMALL_STEP(10), .LARGE_STEP(60),
    .QUICK_TIME(30), .POWER_LEVELS(5), .BLINK_CYCLES(4), .BLINK_TOGGLES(10)
  ) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_start(btn_start),
    .btn_small(btn_small), .btn_large(btn_large), .btn_power(btn_power),
    .btn_stage(btn_stage), .btn_cancel(btn_cancel), .door_open(door_open),
    .state(state), .edit_stage(edit_stage), .run_stage(run_stage),
    .display_time(display_time), .display_power(display_power), .heat_on(heat_on),
    .motor_enable(motor_enable), .button_beep(button_beep),
    .completion_alarm(completion_alarm), .display_blink(display_blink),
    .idle_animation(idle_animation)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_cmp = 0;
  int    n_err = 0;
  int    q_at[$];
  int    q_fld[$];
  int    q_val[$];
  string q_name[$];

  function automatic int actual(input int f);
    case (f)
      F_STATE: return int'(state);
      F_TIME:  return int'(display_time);
      F_POWER: return int'(display_power);
      F_HEAT:  return int'(heat_on);
      F_MOTOR: return int'(motor_enable);
      F_BEEP:  return int'(button_beep);
      F_RUN:   return int'(run_stage);
      F_EDIT:  return int'(edit_stage);
      F_ALARM: return int'(completion_alarm);
      F_BLINK: return int'(display_blink);
      F_IDLE:  return int'(idle_animation);
      default: return -1;
    endcase
  endfunction

  // Expect a value after the coming clock edge.
  task automatic exp_next(input int f, input int v, input string nm);
    q_at.push_back(cyc + 1); q_fld.push_back(f); q_val.push_back(v); q_name.push_back(nm);
  endtask

  // Expect a value already present (checked at the next falling edge).
  task automatic exp_now(input int f, input int v, input string nm);
    q_at.push_back(cyc); q_fld.push_back(f); q_val.push_back(v); q_name.push_back(nm);
  endtask

  int    m_at, m_f, m_v, m_act;
  string m_nm;
  always @(negedge clk) begin
    while (q_at.size() > 0 && q_at[0] <= cyc) begin
      m_at = q_at.pop_front(); m_f = q_fld.pop_front();
      m_v  = q_val.pop_front(); m_nm = q_name.pop_front();
      m_act = actual(m_f);
      n_cmp++;
      if (m_at < cyc) begin
        n_err++;
        $display("FAIL %s: check missed its cycle (due %0d, now %0d)", m_nm, m_at, cyc);
      end else if (m_act != m_v) begin
        n_err++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", m_nm, m_act, m_v, cyc);
      end
    end
  end

  task automatic step(input logic [6:0] b);
    {tick_1hz, btn_start, btn_small, btn_large, btn_power, btn_stage, btn_cancel} = b;
    @(posedge clk);
    #1;
    {tick_1hz, btn_start, btn_small, btn_large, btn_power, btn_stage, btn_cancel} = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0);
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(B_TICK);
      step('0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; door_open = 1'b0;
    {tick_1hz, btn_start, btn_small, btn_large, btn_power, btn_stage, btn_cancel} = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    exp_now(F_STATE, 0, "rst_state"); exp_now(F_BLINK, 1, "rst_blink");
    exp_now(F_IDLE, 1, "rst_idle_anim"); exp_now(F_HEAT, 0, "rst_heat");
    exp_now(F_MOTOR, 0, "rst_motor"); exp_now(F_TIME, 0, "rst_time");
    exp_now(F_POWER, 0, "rst_power"); exp_now(F_ALARM, 0, "rst_alarm");
    idle(1);

    // Express start, 30 s to COMPLETE, then 10 toggles (4 clk each) back to IDLE
    exp_next(F_STATE, 2, "exp_state"); exp_next(F_TIME, 30, "exp_time");
    exp_next(F_POWER, 5, "exp_power"); exp_next(F_HEAT, 1, "exp_heat");
    exp_next(F_MOTOR, 1, "exp_motor"); exp_next(F_BEEP, 1, "exp_beep");
    step(B_START);
    exp_next(F_BEEP, 0, "exp_beep_pulse");
    step('0);
    run_ticks(29);
    exp_now(F_TIME, 1, "exp_time_1");
    exp_next(F_STATE, 4, "exp_complete"); exp_next(F_ALARM, 1, "exp_alarm");
    exp_next(F_BLINK, 1, "exp_blink_start"); exp_next(F_HEAT, 0, "exp_heat_off");
    exp_next(F_MOTOR, 0, "exp_motor_off");
    step(B_TICK);
    idle(3);
    exp_next(F_BLINK, 0, "exp_blink_toggle1");
    step('0);
    idle(34);
    exp_next(F_STATE, 4, "exp_still_complete");
    step('0);
    exp_next(F_STATE, 0, "exp_auto_idle"); exp_next(F_ALARM, 0, "exp_alarm_off");
    exp_next(F_IDLE, 1, "exp_idle_anim"); exp_next(F_BLINK, 1, "exp_blink_idle");
    step('0);

    // Saturation
    exp_next(F_STATE, 1, "sat_setting"); exp_next(F_TIME, 60, "sat_first");
    step(B_LARGE);
    repeat (58) step(B_LARGE);
    exp_next(F_TIME, 3599, "sat_large");
    step(B_LARGE);
    exp_next(F_TIME, 3599, "sat_small"); exp_next(F_BEEP, 1, "sat_beep");
    step(B_SMALL);
    exp_next(F_STATE, 0, "sat_cancel"); exp_next(F_TIME, 0, "sat_cleared");
    exp_next(F_IDLE, 1, "sat_idle_anim");
    step(B_CANCEL);

    // Two stages: 20 s @ power 2, 10 s @ power 5
    step(B_SMALL);
    exp_next(F_TIME, 20, "two_t0");
    step(B_SMALL);
    step(B_POWER);
    exp_next(F_POWER, 2, "two_p0");
    step(B_POWER);
    exp_next(F_EDIT, 1, "two_edit1"); exp_next(F_TIME, 0, "two_t1_empty");
    exp_next(F_POWER, 5, "two_p1");
    step(B_STAGE);
    exp_next(F_TIME, 10, "two_t1");
    step(B_SMALL);
    exp_next(F_STATE, 2, "two_run"); exp_next(F_RUN, 0, "two_run0");
    exp_next(F_TIME, 20, "two_time"); exp_next(F_HEAT, 1, "two_heat0");
    step(B_START);
    for (int k = 1; k < 30; k++) begin
      exp_next(F_HEAT, (k > 20) ? 1 : (((k % 5) < 2) ? 1 : 0), "two_duty");
      if (k == 19) exp_next(F_RUN, 0, "two_still0");
      if (k == 20) begin
        exp_next(F_RUN, 1, "two_advance");
        exp_next(F_TIME, 10, "two_time1");
      end
      step(B_TICK);
      step('0);
    end
    exp_next(F_STATE, 4, "two_complete");
    step(B_TICK);
    exp_next(F_STATE, 0, "two_cancel"); exp_next(F_BEEP, 1, "two_cancel_beep");
    step(B_CANCEL);

    // Door interlock and simultaneous events
    exp_next(F_STATE, 2, "door_run");
    step(B_START);
    run_ticks(15);
    exp_now(F_TIME, 15, "door_t15");
    door_open = 1'b1;
    exp_now(F_HEAT, 0, "door_heat_gate");
    exp_next(F_STATE, 3, "door_paused"); exp_next(F_HEAT, 0, "door_heat");
    exp_next(F_TIME, 15, "door_time");
    step('0);
    exp_next(F_BEEP, 0, "door_no_beep"); exp_next(F_STATE, 3, "door_stay_paused");
    step(B_START);
    door_open = 1'b0;
    exp_next(F_STATE, 2, "door_resume"); exp_next(F_TIME, 15, "door_remaining");
    exp_next(F_BEEP, 1, "door_resume_beep"); exp_next(F_HEAT, 1, "door_heat_back");
    step(B_START);
    exp_next(F_STATE, 3, "tick_start_pause"); exp_next(F_TIME, 15, "tick_discarded");
    step(B_TICK | B_START);
    exp_next(F_STATE, 0, "cancel_start_idle"); exp_next(F_TIME, 0, "cancel_start_time");
    exp_next(F_IDLE, 1, "cancel_start_anim");
    step(B_CANCEL | B_START);

    // Skip empty middle stage, then reset mid-run
    step(B_SMALL);
    step(B_STAGE);
    exp_next(F_EDIT, 2, "skip_edit2");
    step(B_STAGE);
    step(B_SMALL);
    exp_next(F_STATE, 2, "skip_run"); exp_next(F_RUN, 0, "skip_run0");
    exp_next(F_TIME, 10, "skip_t0");
    step(B_START);
    run_ticks(9);
    exp_next(F_RUN, 2, "skip_run2"); exp_next(F_TIME, 10, "skip_t2");
    exp_next(F_STATE, 2, "skip_still_run");
    step(B_TICK);
    step('0);
    run_ticks(2);
    reset = 1'b1;
    exp_next(F_STATE, 0, "mid_rst_state"); exp_next(F_HEAT, 0, "mid_rst_heat");
    exp_next(F_MOTOR, 0, "mid_rst_motor"); exp_next(F_BLINK, 1, "mid_rst_blink");
    exp_next(F_IDLE, 1, "mid_rst_anim"); exp_next(F_TIME, 0, "mid_rst_time");
    exp_next(F_POWER, 0, "mid_rst_power"); exp_next(F_ALARM, 0, "mid_rst_alarm");
    exp_next(F_RUN, 0, "mid_rst_run");
    step('0);
    reset = 1'b0;
    idle(3);

    if (q_at.size() > 0) begin
      $display("FAIL scoreboard_drain: %0d checks left unchecked, expected 0", q_at.size());
      n_err += q_at.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
